// File: rtl/fft_pkg.sv
// Shared constants and width helpers for the twiddle multiplier pipeline.
// Holds the twiddle coefficient generator used to build the ROM at elaboration.
package fft_pkg;

   // Coefficients are Q(NBITScoeff-2): unity maps to S = 2^(NBITScoeff-2).
   function automatic int coeff_shift(input int nbits_coeff);
      return nbits_coeff - 2;
   endfunction

   function automatic int coeff_scale(input int nbits_coeff);
      return 1 << coeff_shift(nbits_coeff);
   endfunction

   function automatic int prod_width(input int nbits, input int nbits_coeff);
      return nbits + nbits_coeff;
   endfunction

   function automatic int out_width(input int nbits, input int nbits_coeff);
      return prod_width(nbits, nbits_coeff) + 1;
   endfunction

   function automatic int twiddle_idx_w(input int npoints);
      return $clog2(npoints);
   endfunction

   function automatic int frame_cnt_w(input int frame_len);
      return $clog2(frame_len);
   endfunction

   // cos(2*pi*k/N)*S or -sin(2*pi*k/N)*S, rounded half away from zero.
   function automatic int tw_coeff(input int k, input int npoints,
                                   input int nbits_coeff, input logic imag);
      real ang;
      real v;
      ang = 2.0 * 3.14159265358979323846 * real'(k) / real'(npoints);
      v   = imag ? -$sin(ang) : $cos(ang);
      v   = v * real'(coeff_scale(nbits_coeff));
      return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Twiddle ROM: table built at elaboration, registered read of cr/ci.
// Registered outputs follow the index by one clock.
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int NPOINTS    = 128,
   parameter int NBITScoeff = 11
) (
   input  logic                                  clk,
   input  logic [twiddle_idx_w(NPOINTS)-1:0]     k,
   output logic signed [NBITScoeff-1:0]          cr,
   output logic signed [NBITScoeff-1:0]          ci
);

   logic signed [NBITScoeff-1:0] w_cos_tab [NPOINTS];
   logic signed [NBITScoeff-1:0] w_sin_tab [NPOINTS];

   generate
      for (genvar gi = 0; gi < NPOINTS; gi++) begin : g_tab
         assign w_cos_tab[gi] = NBITScoeff'(tw_coeff(gi, NPOINTS, NBITScoeff, 1'b0));
         assign w_sin_tab[gi] = NBITScoeff'(tw_coeff(gi, NPOINTS, NBITScoeff, 1'b1));
      end
   endgenerate

   always_ff @(posedge clk) begin
      cr <= w_cos_tab[k];
      ci <= w_sin_tab[k];
   end

endmodule

// File: rtl/twiddle_mult_pipe.sv
// Three-stage complex multiply of each sample by its frame-position twiddle.
// Define TRIVIAL_BYPASS_EN to route k=0 and k=NPOINTS/4 through shift/negate.
module twiddle_mult_pipe
   import fft_pkg::*;
#(
   parameter int NBITS      = 12,
   parameter int NBITScoeff = 11,
   parameter int NBITS_out  = out_width(NBITS, NBITScoeff),
   parameter int NPOINTS    = 128,
   parameter int FRAME_LEN  = 128,
   parameter int TW_STRIDE  = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2*NBITS-1:0]     muestra,
   input  logic                   sync_in,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*NBITS_out-1:0] result
);

   localparam int KW = twiddle_idx_w(NPOINTS);
   localparam int CW = frame_cnt_w(FRAME_LEN);
   localparam int NP = prod_width(NBITS, NBITScoeff);

   logic                         w_en;
   logic [CW-1:0]                r_cnt;
   logic [CW-1:0]                w_cnt_used;
   logic [CW-1:0]                w_cnt_next;
   logic [KW-1:0]                w_k_new;
   logic [KW-1:0]                w_rom_k;
   logic [KW-1:0]                r_s1_k;
   logic                         r_s1_valid;
   logic signed [NBITS-1:0]      r_s1_mr;
   logic signed [NBITS-1:0]      r_s1_mi;
   logic signed [NBITScoeff-1:0] w_cr;
   logic signed [NBITScoeff-1:0] w_ci;
   logic signed [NP-1:0]         w_prr, w_pii, w_pri, w_pir;
   logic signed [NP-1:0]         r_prr, r_pii, r_pri, r_pir;
   logic                         r_s2_valid;
   logic signed [NBITS_out-1:0]  w_res_r, w_res_i;
   logic                         r_out_valid;
   logic [2*NBITS_out-1:0]       r_result;

   assign w_en      = out_ready || !r_out_valid;
   assign in_ready  = w_en;
   assign out_valid = r_out_valid;
   assign result    = r_result;

   // A sync sample restarts the frame at position 0.
   assign w_cnt_used = sync_in ? '0 : r_cnt;
   assign w_cnt_next = (w_cnt_used == CW'(FRAME_LEN - 1)) ? '0 : w_cnt_used + CW'(1);
   assign w_k_new    = KW'(w_cnt_used) * KW'(TW_STRIDE);

   // While stalled, re-read the held index so the ROM output stays aligned with stage 1.
   assign w_rom_k = w_en ? w_k_new : r_s1_k;

   twiddle_rom #(
      .NPOINTS    (NPOINTS),
      .NBITScoeff (NBITScoeff)
   ) u_rom (
      .clk (clk),
      .k   (w_rom_k),
      .cr  (w_cr),
      .ci  (w_ci)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_cnt      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_k     <= '0;
         r_s1_mr    <= '0;
         r_s1_mi    <= '0;
      end else if (w_en) begin
         r_s1_valid <= in_valid;
         r_s1_k     <= w_k_new;
         r_s1_mr    <= muestra[2*NBITS-1:NBITS];
         r_s1_mi    <= muestra[NBITS-1:0];
         if (in_valid)
            r_cnt <= w_cnt_next;
      end
   end

`ifdef TRIVIAL_BYPASS_EN
   localparam int SH = coeff_shift(NBITScoeff);
   logic signed [NP-1:0] w_mr_sc;
   logic signed [NP-1:0] w_mi_sc;
   assign w_mr_sc = NP'(r_s1_mr) <<< SH;
   assign w_mi_sc = NP'(r_s1_mi) <<< SH;
`endif

   always_comb begin
      w_prr = NP'(r_s1_mr) * NP'(w_cr);
      w_pii = NP'(r_s1_mi) * NP'(w_ci);
      w_pri = NP'(r_s1_mr) * NP'(w_ci);
      w_pir = NP'(r_s1_mi) * NP'(w_cr);
`ifdef TRIVIAL_BYPASS_EN
      if (r_s1_k == '0) begin
         w_prr = w_mr_sc;
         w_pii = '0;
         w_pri = '0;
         w_pir = w_mi_sc;
      end else if (r_s1_k == KW'(NPOINTS / 4)) begin
         w_prr = '0;
         w_pii = -w_mi_sc;
         w_pri = -w_mr_sc;
         w_pir = '0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s2_valid <= 1'b0;
         r_prr      <= '0;
         r_pii      <= '0;
         r_pri      <= '0;
         r_pir      <= '0;
      end else if (w_en) begin
         r_s2_valid <= r_s1_valid;
         r_prr      <= w_prr;
         r_pii      <= w_pii;
         r_pri      <= w_pri;
         r_pir      <= w_pir;
      end
   end

   assign w_res_r = NBITS_out'(r_prr) - NBITS_out'(r_pii);
   assign w_res_i = NBITS_out'(r_pri) + NBITS_out'(r_pir);

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_result    <= '0;
      end else if (w_en) begin
         r_out_valid <= r_s2_valid;
         r_result    <= {w_res_r, w_res_i};
      end
   end

endmodule

// File: tb/tb_twiddle_mult_pipe.sv
// Bench for twiddle_mult_pipe: directed and random streams against a cos/sin reference model.
module tb_twiddle_mult_pipe;

   localparam int NB = 12;
   localparam int NO = 24;
   localparam int NPTS = 128;
   localparam int FL = 128;
   localparam int STRIDE = 1;
   localparam real SCALE = 512.0;

   typedef struct {
      longint r;
      longint i;
   } pair_t;

   logic clk = 1'b0;
   logic rst, in_valid, in_ready, sync_in, out_valid, out_ready;
   logic [2*NB-1:0] muestra;
   logic [2*NO-1:0] result;

   int n_checks = 0;
   int n_pass = 0;
   pair_t exp_q[$];
   pair_t out_log[$];
   int m_cnt = 0;

   always #5 clk = ~clk;

   twiddle_mult_pipe dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .muestra   (muestra),
      .sync_in   (sync_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   function automatic longint tw(input int k, input bit imag);
      real a, v;
      a = 2.0 * 3.14159265358979323846 * real'(k) / real'(NPTS);
      v = (imag ? -$sin(a) : $cos(a)) * SCALE;
      return (v >= 0.0) ? longint'($rtoi(v + 0.5)) : longint'($rtoi(v - 0.5));
   endfunction

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Reference model and scoreboard, evaluated mid-cycle before the capturing edge.
   always @(negedge clk) begin : monitor
      pair_t e, g;
      longint mr, mi, cr, ci;
      int u, k;
      if (!rst) begin
         exp_q.delete();
         m_cnt = 0;
      end else begin
         if (out_valid && out_ready) begin
            check("output_expected", longint'(exp_q.size() > 0), 1);
            g.r = longint'($signed(result[2*NO-1:NO]));
            g.i = longint'($signed(result[NO-1:0]));
            out_log.push_back(g);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("res_re", g.r, e.r);
               check("res_im", g.i, e.i);
            end
         end
         if (in_valid && in_ready) begin
            u  = sync_in ? 0 : m_cnt;
            k  = (u * STRIDE) % NPTS;
            cr = tw(k, 1'b0);
            ci = tw(k, 1'b1);
            mr = longint'($signed(muestra[2*NB-1:NB]));
            mi = longint'($signed(muestra[NB-1:0]));
            e.r = mr * cr - mi * ci;
            e.i = mr * ci + mi * cr;
            exp_q.push_back(e);
            m_cnt = (u + 1) % FL;
         end
      end
   end

   function automatic int rnd();
      return int'($urandom_range(4095)) - 2048;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit v, input bit s, input int mr, input int mi);
      in_valid = v;
      sync_in  = s;
      muestra  = {NB'(mr), NB'(mi)};
   endtask

   task automatic send(input int mr, input int mi, input bit s);
      bit acc;
      acc = 1'b0;
      set_in(1'b1, s, mr, mi);
      for (int t = 0; t < 50 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         tick();
      end
      if (!acc) check("send_timeout", longint'(acc), 1);
   endtask

   task automatic drain();
      in_valid = 1'b0;
      sync_in  = 1'b0;
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) tick();
      check("drain_empty", longint'(exp_q.size()), 0);
   endtask

   // Frame starting with sync; the sample at position kt carries the given data.
   task automatic run_to_k(input int kt, input int mr, input int mi);
      for (int j = 0; j <= kt; j++) begin
         if (j == kt) send(mr, mi, j == 0);
         else         send(rnd(), rnd(), j == 0);
      end
      drain();
   endtask

   initial begin
      pair_t held;
      int n0;
      int cur_mr, cur_mi;
      bit first, acc;
      logic [2*NO-1:0] held_res;

      rst = 1'b0;
      out_ready = 1'b1;
      set_in(1'b1, 1'b0, 5, 5);
      repeat (3) tick();
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_result", result, 0);
      tick();
      rst = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      check("in_ready_after_rst", in_ready, 1);
      tick();

      // Single sample at k=0, exact three-cycle latency.
      set_in(1'b1, 1'b1, 100, -50);
      @(negedge clk);
      check("accept_first", in_ready, 1);
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("latency", out_valid, longint'(i == 3));
         tick();
      end
      held = out_log[out_log.size() - 1];
      check("k0_re", held.r, 51200);
      check("k0_im", held.i, -25600);

      run_to_k(32, 100, -50);
      held = out_log[out_log.size() - 1];
      check("k32_re", held.r, -25600);
      check("k32_im", held.i, -51200);

      run_to_k(16, 1000, 0);
      held = out_log[out_log.size() - 1];
      check("k16a_re", held.r, 362000);
      check("k16a_im", held.i, -362000);

      run_to_k(16, -2048, -2048);
      held = out_log[out_log.size() - 1];
      check("k16b_re", held.r, -1482752);
      check("k16b_im", held.i, 0);

      // Backpressure: out_ready low for 5 cycles in a continuous stream.
      first = 1'b1;
      cur_mr = rnd();
      cur_mi = rnd();
      held_res = '0;
      for (int c = 0; c < 24; c++) begin
         out_ready = !(c >= 8 && c < 13);
         set_in(1'b1, first, cur_mr, cur_mi);
         @(negedge clk);
         acc = in_ready;
         if (c == 8) held_res = result;
         if (c == 10) check("stall_in_ready", in_ready, 0);
         if (c > 8 && c < 13) begin
            check("stall_hold", result, held_res);
            check("stall_valid", out_valid, 1);
         end
         tick();
         if (acc) begin
            first = 1'b0;
            cur_mr = rnd();
            cur_mi = rnd();
         end
      end
      out_ready = 1'b1;
      drain();

      // Resync at frame position 70.
      send(rnd(), rnd(), 1'b1);
      for (int j = 1; j < 70; j++) send(rnd(), rnd(), 1'b0);
      send(100, -50, 1'b1);
      send(100, -50, 1'b0);
      drain();
      held = out_log[out_log.size() - 2];
      check("resync_k0_re", held.r, 51200);
      check("resync_k0_im", held.i, -25600);
      held = out_log[out_log.size() - 1];
      check("resync_k1_re", held.r, 49850);
      check("resync_k1_im", held.i, -28050);

      // Reset in the middle of a full pipeline.
      for (int j = 0; j < 10; j++) send(rnd(), rnd(), j == 0);
      rst = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("rst_mid_valid", out_valid, 0);
      tick();
      rst = 1'b1;
      in_valid = 1'b0;
      n0 = out_log.size();
      repeat (6) tick();
      check("no_stale", longint'(out_log.size()), longint'(n0));

      // Random traffic with random backpressure and occasional resync.
      for (int c = 0; c < 400; c++) begin
         out_ready = ($urandom_range(2) != 0);
         set_in($urandom_range(3) != 0, $urandom_range(39) == 0, rnd(), rnd());
         tick();
      end
      out_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
